// File: rtl/traffic_phase_if.sv
// Controller-facing bundle for the multi-phase signal controller: timebase,
// requests in, lamp drives and phase status out.
interface traffic_phase_if #(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned PW         = 3
);
  logic                  tick;
  logic [NUM_PHASES-1:0] extension;
  logic [NUM_PHASES-1:0] demand;
  logic                  preempt;
  logic [PW-1:0]         preempt_phase;
  logic [NUM_PHASES-1:0] green;
  logic [NUM_PHASES-1:0] yellow;
  logic [NUM_PHASES-1:0] red;
  logic [PW-1:0]         active_phase;
  logic [1:0]            phase_state;

  modport master (
    output tick, extension, demand, preempt, preempt_phase,
    input  green, yellow, red, active_phase, phase_state
  );

  modport slave (
    input  tick, extension, demand, preempt, preempt_phase,
    output green, yellow, red, active_phase, phase_state
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Multi-phase traffic controller: GREEN/YELLOW/ALLRED sequencing with bounded
// green extension, optional demand-actuated skipping and emergency preemption.
module traffic_phase_ctrl #(
  parameter int unsigned NUM_PHASES  = 4,
  parameter int unsigned PW          = 3,
  parameter int unsigned TW          = 8,
  parameter int unsigned GREEN_TIME  = 10,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 1,
  parameter int unsigned EXT_TIME    = 4,
  parameter int unsigned MAX_EXT     = 2,
  parameter int unsigned DEMAND_MODE = 0
) (
  input logic           clk,
  input logic           reset,
  traffic_phase_if.slave bus
);

  localparam int unsigned NPP = 1 << PW;
  localparam int unsigned EW  = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;

  state_t                st_q, st_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [PW-1:0]         next_q, next_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [EW-1:0]         ext_q, ext_d;
  logic                  hold_q, hold_d;
  logic [NPP-1:0]        dl_q, dl_d;
  logic [NUM_PHASES-1:0] green_q, green_d;
  logic [NUM_PHASES-1:0] yellow_q, yellow_d;
  logic [NUM_PHASES-1:0] red_q, red_d;

  logic [NPP-1:0] ext_pad;
  logic [NPP-1:0] dem_pad;
  logic           pre_valid;
  logic           terminal;
  logic           ext_grant;
  logic           found;
  logic [PW-1:0]  found_idx;
  logic [PW-1:0]  rot_next;

  // Request vectors padded to the full index space so any phase index selects cleanly.
  assign ext_pad   = NPP'(bus.extension);
  assign dem_pad   = NPP'(bus.demand);
  assign pre_valid = bus.preempt && (32'(bus.preempt_phase) < NUM_PHASES);
  assign terminal  = bus.tick && (cnt_q == TW'(1));
  assign ext_grant = terminal && ext_pad[phase_q] && (32'(ext_q) < MAX_EXT);
  assign rot_next  = (phase_q == PW'(NUM_PHASES - 1)) ? '0 : phase_q + PW'(1);

  // Circular search for the first latched call after the active phase.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int unsigned k = 1; k < NUM_PHASES; k++) begin
      if (!found && dl_q[PW'((32'(phase_q) + k) % NUM_PHASES)]) begin
        found     = 1'b1;
        found_idx = PW'((32'(phase_q) + k) % NUM_PHASES);
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    phase_d = phase_q;
    next_d  = next_q;
    cnt_d   = cnt_q;
    ext_d   = ext_q;
    hold_d  = 1'b0;

    case (st_q)
      ST_GREEN: begin
        if (pre_valid && (bus.preempt_phase != phase_q)) begin
          st_d   = ST_YELLOW;
          cnt_d  = TW'(YELLOW_TIME);
          next_d = bus.preempt_phase;
        end else if (pre_valid) begin
          hold_d = 1'b1;
        end else if (hold_q) begin
          // Preemption just released: restart a full green.
          cnt_d = TW'(GREEN_TIME);
          ext_d = '0;
        end else if (ext_grant) begin
          cnt_d = TW'(EXT_TIME);
          ext_d = ext_q + EW'(1);
        end else if (terminal) begin
          if (DEMAND_MODE == 0) begin
            st_d   = ST_YELLOW;
            cnt_d  = TW'(YELLOW_TIME);
            next_d = rot_next;
          end else if (found) begin
            st_d   = ST_YELLOW;
            cnt_d  = TW'(YELLOW_TIME);
            next_d = found_idx;
          end
        end else if (bus.tick) begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      ST_YELLOW: begin
        if (pre_valid) next_d = bus.preempt_phase;
        if (terminal) begin
          st_d  = ST_ALLRED;
          cnt_d = TW'(ALLRED_TIME);
        end else if (bus.tick) begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      default: begin
        if (terminal) begin
          st_d    = ST_GREEN;
          phase_d = pre_valid ? bus.preempt_phase : next_q;
          cnt_d   = TW'(GREEN_TIME);
          ext_d   = '0;
        end else begin
          if (pre_valid) next_d = bus.preempt_phase;
          if (bus.tick) cnt_d = cnt_q - TW'(1);
        end
      end
    endcase

    // Call latches: cleared on green entry, a concurrent call wins.
    dl_d = dl_q;
    if ((st_d == ST_GREEN) && (st_q != ST_GREEN)) dl_d[phase_d] = 1'b0;
    dl_d = (DEMAND_MODE != 0) ? (dl_d | dem_pad) : '0;

    green_d  = '0;
    yellow_d = '0;
    if (st_d == ST_GREEN)  green_d  = NUM_PHASES'(1) << phase_d;
    if (st_d == ST_YELLOW) yellow_d = NUM_PHASES'(1) << phase_d;
    red_d = ~(green_d | yellow_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= ST_ALLRED;
      phase_q  <= '0;
      next_q   <= '0;
      cnt_q    <= TW'(ALLRED_TIME);
      ext_q    <= '0;
      hold_q   <= 1'b0;
      dl_q     <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
    end else begin
      st_q     <= st_d;
      phase_q  <= phase_d;
      next_q   <= next_d;
      cnt_q    <= cnt_d;
      ext_q    <= ext_d;
      hold_q   <= hold_d;
      dl_q     <= dl_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
    end
  end

  assign bus.green        = green_q;
  assign bus.yellow       = yellow_q;
  assign bus.red          = red_q;
  assign bus.active_phase = phase_q;
  assign bus.phase_state  = st_q;

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised successor to the two-way traffic controller. Sequences NUM_PHASES mutually exclusive signal phases through GREEN, YELLOW and ALLRED intervals, all timed in ticks of the shared one-second tick pulse. Adds:
- per-phase bounded green extension;
- optional demand-actuated phase skipping;
- emergency preemption.

It sits beside the tick generator and replaces the fixed NS/EW controller at multi-approach intersections.

Parameters:
- NUM_PHASES, 4, number of phases, legal range 2..8.
- PW, 3, phase index width; must satisfy 2**PW >= NUM_PHASES.
- TW, 8, interval counter width.
- GREEN_TIME, 10, base green duration in ticks, >=1.
- YELLOW_TIME, 3, yellow duration in ticks, >=1.
- ALLRED_TIME, 1, all-red clearance in ticks, >=1.
- EXT_TIME, 4, ticks added per granted extension, >=1.
- MAX_EXT, 2, maximum extensions per green interval; 0 disables extension.
- DEMAND_MODE, 0, 0 = fixed rotation, 1 = demand-actuated skipping.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-clock timebase pulse.
- extension  in  NUM_PHASES  per-phase extension request, level.
- demand  in  NUM_PHASES  per-phase call request, level; ignored when DEMAND_MODE=0.
- preempt  in  1  emergency preemption request, level.
- preempt_phase  in  PW  phase to serve during preemption.
- green  out  NUM_PHASES  green lamp per phase.
- yellow  out  NUM_PHASES  yellow lamp per phase.
- red  out  NUM_PHASES  red lamp per phase.
- active_phase  out  PW  phase currently owning the interval.
- phase_state  out  2  00 = ALLRED, 01 = GREEN, 10 = YELLOW.

Behaviour:
- Reset (reset=0, asynchronous):
  - state ALLRED, active_phase=0, counter=ALLRED_TIME, ext_cnt=0, demand latches cleared;
  - outputs: red=all 1, green=0, yellow=0.
- Outputs are decoded only from registered state. No combinational path from any input to any lamp.
- Lamp invariants:
  - each phase drives exactly one lamp;
  - at most one phase is non-red;
  - in ALLRED every phase is red.
- Timing: the counter decrements only on clk edges with tick=1. An interval ends on the edge where tick=1 and counter==1.
- On every state entry the counter is loaded with that interval's duration. A GREEN therefore lasts exactly GREEN_TIME ticks, plus any extensions.
- Transitions:
  - ALLRED -> GREEN of next_phase; ext_cnt is cleared and counter loads GREEN_TIME.
  - GREEN -> YELLOW of the same phase.
  - YELLOW -> ALLRED; the phase index is unchanged until the ALLRED exit.
- next_phase, fixed mode: (active_phase+1) mod NUM_PHASES.
- Extension:
  - Granted on a terminal GREEN tick (tick=1, counter==1) when extension[active_phase]=1 and ext_cnt<MAX_EXT.
  - A grant reloads the counter with EXT_TIME and increments ext_cnt, and the state stays GREEN.
  - Requests on any other cycle are ignored.
- Demand mode (DEMAND_MODE=1):
  - demand_latch[i] is set in any cycle where demand[i]=1.
  - demand_latch[i] is cleared on entry to GREEN of phase i; set has priority in the same cycle.
  - On a terminal GREEN tick with no extension granted, the controller searches circularly from active_phase+1 for a latched phase, excluding active_phase.
  - No latched phase found: rest in GREEN with the counter held at 1, re-evaluating each tick.
  - Latched phase found: go to YELLOW; the found phase becomes next_phase.
- Preemption (active when preempt=1 and preempt_phase<NUM_PHASES; otherwise preempt is ignored):
  - In GREEN of another phase: enter YELLOW on the next clk edge, independent of tick.
  - In YELLOW or ALLRED: the interval completes normally, and next_phase is forced to preempt_phase.
  - In GREEN of preempt_phase: the counter is frozen; extensions and demand advance are suppressed.
  - When preempt deasserts during a held GREEN, the counter reloads GREEN_TIME and ext_cnt clears; normal operation resumes.
  - Preemption has priority over extension and demand when they coincide.
- Mid-operation reset: returns immediately to the reset state, all red.

Test Plan:
- Fixed rotation. NUM_PHASES=2, GREEN=5, YELLOW=2, ALLRED=1; release reset, then apply ticks.
  - Required: 1 tick ALLRED; phase0 green 5 ticks, yellow 2, ALLRED 1; phase1 green 5; full cycle 16 ticks.
  - Assert the lamp invariants every cycle.
- Extension. Hold extension[0]=1 throughout, EXT_TIME=4, MAX_EXT=2.
  - Required: phase0 green lasts 5+4+4=13 ticks, then yellow. A third request is ignored.
- Late extension. Pulse extension[0] on a non-terminal tick only.
  - Required: no extension; green lasts exactly 5 ticks.
- Demand mode. NUM_PHASES=4; pulse demand[2] once while phase0 is green.
  - Required: phases 1 and 3 are skipped; the sequence is 0 -> 2. With no further demand, phase2 rests in green indefinitely.
- Preemption. Assert preempt with preempt_phase=1 on tick 2 of phase0 green.
  - Required: yellow on the next clk edge; ALLRED; phase1 green held while preempt=1.
  - Release: phase1 green runs 5 more ticks.
  - preempt_phase=7 with NUM_PHASES=4 has no effect.
- Reset mid-GREEN. Drop reset asynchronously between clk edges.
  - Required: all red immediately; active_phase=0; restart begins with 1 tick ALLRED.
